// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : PC owner, single-outstanding instruction fetch, redirect/kill.
//              Optional feature macro: FETCH_MISALIGN_TRAP_EN.
// Revision   : 1.0
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  branch,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic [31:0] alu_out,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        flush
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign_err
`endif
);

  // 2'b00 and the reserved 2'b11 both mean "keep going sequentially".
  localparam logic [1:0]  PC_MUX_BRANCH = 2'b01;
  localparam logic [1:0]  PC_MUX_ALU    = 2'b10;
  localparam logic [31:0] NOP           = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    KILL = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] pend_addr, pend_addr_n;
  logic        pend, pend_n;
  logic        stale, stale_n;
  logic        buf_valid_n;
  logic [31:0] buf_instr_n, buf_pc_n;
  logic        flush_n;
  logic        redirect, accept, issue, park;
  logic [31:0] target_raw, target;

  assign redirect   = branch_valid && (branch == PC_MUX_BRANCH || branch == PC_MUX_ALU);
  assign target_raw = (branch == PC_MUX_ALU) ? alu_out : branch_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign, err_n;
  assign misalign = redirect && (target_raw[1:0] != 2'b00);
  assign target   = target_raw;
  assign park     = misalign_err;
`else
  assign target   = target_raw & 32'hFFFF_FFFC;
  assign park     = 1'b0;
`endif

  // pend: a request was presented last cycle and not taken; it must be held.
  assign issue          = (state == REQ) && !pend && !redirect && (!if_valid || if_ready);
  assign imem_req_valid = pend || issue;
  assign imem_req_addr  = pend ? pend_addr : pc;
  assign accept         = imem_req_valid && imem_req_ready;

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    fetch_pc_n  = fetch_pc;
    pend_n      = pend;
    pend_addr_n = pend_addr;
    stale_n     = stale;
    buf_valid_n = if_valid;
    buf_instr_n = if_instr;
    buf_pc_n    = if_pc;
    flush_n     = redirect;
`ifdef FETCH_MISALIGN_TRAP_EN
    err_n       = misalign_err;
`endif

    if (if_valid && if_ready) buf_valid_n = 1'b0;

    if (accept) begin
      pend_n  = 1'b0;
      stale_n = 1'b0;
    end else if (imem_req_valid) begin
      pend_n      = 1'b1;
      pend_addr_n = imem_req_addr;
    end

    case (state)
      IDLE: if (!park) state_n = REQ;
      REQ: begin
        if (accept) begin
          fetch_pc_n = imem_req_addr;
          if (stale) begin
            state_n = KILL;
          end else begin
            state_n = WAIT;
            pc_n    = imem_req_addr + 32'd4;
          end
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          buf_valid_n = 1'b1;
          buf_instr_n = imem_rsp_data;
          buf_pc_n    = fetch_pc;
          state_n     = REQ;
        end
      end
      KILL: if (imem_rsp_valid) state_n = REQ;
      default: state_n = IDLE;
    endcase

    // A request held across a redirect is marked stale so its response is killed.
    if (redirect) begin
      pc_n        = target;
      buf_valid_n = 1'b0;
      if (pend && !accept) stale_n = 1'b1;
      case (state)
        REQ:     if (accept) state_n = KILL;
        WAIT:    state_n = imem_rsp_valid ? REQ : KILL;
        default: ;
      endcase
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    if (misalign) begin
      err_n   = 1'b1;
      state_n = IDLE;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      fetch_pc  <= RESET_PC;
      pend      <= 1'b0;
      pend_addr <= RESET_PC;
      stale     <= 1'b0;
      if_valid  <= 1'b0;
      if_instr  <= NOP;
      if_pc     <= RESET_PC;
      flush     <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      fetch_pc  <= fetch_pc_n;
      pend      <= pend_n;
      pend_addr <= pend_addr_n;
      stale     <= stale_n;
      if_valid  <= buf_valid_n;
      if_instr  <= buf_instr_n;
      if_pc     <= buf_pc_n;
      flush     <= flush_n;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_err <= 1'b0;
    else        misalign_err <= err_n;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// tb_fetch_unit: redirect vector table plus scoreboarded multi-cycle fetch sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  branch = 2'b00;
  logic        branch_valid = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] alu_out = 32'h0;
  logic        imem_req_valid;
  logic        mem_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .branch        (branch),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .alu_out       (alu_out),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(mem_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .flush         (flush)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_err  (misalign_err)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic        bv;
    logic [1:0]  br;
    logic [31:0] tgt;
    logic [31:0] alu;
    logic        exp_flush;
    logic        exp_park;
    logic [31:0] exp_addr;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  int          lat = 1;
  int          cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  logic        sb_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] acc_q[$];
  exp_t        exp_q[$];
  vec_t        vt[8];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h00A0_0093;
      32'h0000_0004: return 32'h0010_0113;
      default:       return {a[23:0], 8'h13};
    endcase
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    return (acc_q.size() > i) ? acc_q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_q.push_back({a, mem_word(a)});
  endtask

  // Memory: accepts are sampled mid-cycle; the response is driven lat cycles later.
  always begin
    @(negedge clk);
    if (!rst_n) begin
      cnt            = 0;
      imem_rsp_valid = 1'b0;
    end else begin
      imem_rsp_valid = (cnt == 1);
      if (cnt == 1) imem_rsp_data = mem_word(mem_addr);
      if (cnt > 0) cnt--;
    end
    #2;
    if (rst_n && imem_req_valid && mem_ready) begin
      cnt      = lat;
      mem_addr = imem_req_addr;
    end
  end

  // Monitor: request log, request-hold stability, decode-side scoreboard.
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (imem_req_valid && mem_ready) acc_q.push_back(imem_req_addr);
      if (prev_stall) begin
        check("req_hold_valid", {63'd0, imem_req_valid}, 64'd1);
        check("req_hold_addr", {32'd0, imem_req_addr}, {32'd0, prev_addr});
      end
      prev_stall = imem_req_valid && !mem_ready;
      prev_addr  = imem_req_addr;
      if (sb_en && if_valid && if_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_instr: got pc %0h instr %0h expected none", if_pc, if_instr);
        end else begin
          check("sb_pc_instr", {if_pc, if_instr}, exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_reset(input int l, input logic rdy, input logic ifr);
    @(negedge clk);
    rst_n         = 1'b0;
    lat           = l;
    mem_ready     = rdy;
    if_ready      = ifr;
    branch_valid  = 1'b0;
    branch        = 2'b00;
    branch_target = 32'h0;
    alu_out       = 32'h0;
    sb_en         = 1'b0;
    repeat (2) @(negedge clk);
    acc_q.delete();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #3;
    end
    check(name, {63'd0, exp_q.size() == 0}, 64'd1);
    sb_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic found;
    //        bv    br     tgt            alu            flush park  first request
    vt[0] = '{1'b0, 2'b01, 32'h0000_0100, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000};
    vt[1] = '{1'b1, 2'b00, 32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0, 32'h0000_0000};
    vt[2] = '{1'b1, 2'b11, 32'h0000_0300, 32'h0000_0340, 1'b0, 1'b0, 32'h0000_0000};
    vt[3] = '{1'b1, 2'b01, 32'h0000_0100, 32'h0000_0500, 1'b1, 1'b0, 32'h0000_0100};
    vt[4] = '{1'b1, 2'b10, 32'h0000_0100, 32'h0000_0200, 1'b1, 1'b0, 32'h0000_0200};
    vt[6] = '{1'b1, 2'b10, 32'h0000_0000, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'hFFFF_FFFC};
`ifdef FETCH_MISALIGN_TRAP_EN
    vt[5] = '{1'b1, 2'b01, 32'h0000_0102, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000};
    vt[7] = '{1'b1, 2'b10, 32'h0000_0000, 32'h0000_0203, 1'b1, 1'b1, 32'h0000_0000};
`else
    vt[5] = '{1'b1, 2'b01, 32'h0000_0102, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0100};
    vt[7] = '{1'b1, 2'b10, 32'h0000_0000, 32'h0000_0203, 1'b1, 1'b0, 32'h0000_0200};
`endif

    // Redirect vectors applied in the first REQ cycle; decode stalled so one word parks.
    for (int v = 0; v < 8; v++) begin
      do_reset(1, 1'b1, 1'b0);
      @(negedge clk);
      branch_valid  = vt[v].bv;
      branch        = vt[v].br;
      branch_target = vt[v].tgt;
      alu_out       = vt[v].alu;
      @(negedge clk);
      branch_valid = 1'b0;
      #3;
      check($sformatf("v%0d_flush", v), {63'd0, flush}, {63'd0, vt[v].exp_flush});
      repeat (8) @(negedge clk);
      #3;
      if (vt[v].exp_park) begin
        check($sformatf("v%0d_no_req", v), acc_q.size(), 64'd0);
        check($sformatf("v%0d_if_valid", v), {63'd0, if_valid}, 64'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check($sformatf("v%0d_misalign_err", v), {63'd0, misalign_err}, 64'd1);
`endif
      end else begin
        check($sformatf("v%0d_req_count", v), acc_q.size(), 64'd1);
        check($sformatf("v%0d_req_addr", v), {32'd0, acc_at(0)}, {32'd0, vt[v].exp_addr});
        check($sformatf("v%0d_if_valid", v), {63'd0, if_valid}, 64'd1);
        check($sformatf("v%0d_if_word", v), {if_pc, if_instr},
              {vt[v].exp_addr, mem_word(vt[v].exp_addr)});
      end
    end

    // Asynchronous reset mid-cycle, reset values, then sequential fetch.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    check("rst_req_addr", {32'd0, imem_req_addr}, 64'd0);
    check("rst_if_valid", {63'd0, if_valid}, 64'd0);
    check("rst_if_instr", {32'd0, if_instr}, 64'h13);
    check("rst_if_pc", {32'd0, if_pc}, 64'd0);
    check("rst_flush", {63'd0, flush}, 64'd0);
    lat          = 1;
    mem_ready    = 1'b1;
    if_ready     = 1'b1;
    branch_valid = 1'b0;
    repeat (2) @(negedge clk);
    acc_q.delete();
    exp_q.delete();
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h8);
    sb_en = 1'b1;
    rst_n = 1'b1;
    #3;
    check("idle_no_req", {63'd0, imem_req_valid}, 64'd0);
    @(negedge clk);
    #3;
    check("first_req", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, 32'h0});
    drain("seq_drain");
    check("seq_req0", {32'd0, acc_at(0)}, 64'h0);
    check("seq_req1", {32'd0, acc_at(1)}, 64'h4);
    check("seq_req2", {32'd0, acc_at(2)}, 64'h8);

    // Decode stall right after the first instruction is taken.
    do_reset(1, 1'b1, 1'b1);
    push_exp(32'h0);
    push_exp(32'h4);
    sb_en = 1'b1;
    for (int i = 0; i < 30 && exp_q.size() != 1; i++) begin
      @(negedge clk);
      #3;
    end
    check("stall_first_taken", exp_q.size(), 64'd1);
    @(negedge clk);
    if_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #3;
      if (i >= 1) begin
        check("stall_if_valid", {63'd0, if_valid}, 64'd1);
        check("stall_if_word", {if_pc, if_instr}, {32'h4, 32'h0010_0113});
      end
      @(negedge clk);
    end
    check("stall_req_count", acc_q.size(), 64'd2);
    check("stall_req_addr", {32'd0, acc_at(1)}, 64'h4);
    if_ready = 1'b1;
    drain("stall_drain");

    // Redirect while WAITing on 0x8 with a 3-cycle memory: response killed.
    do_reset(3, 1'b1, 1'b1);
    push_exp(32'h0);
    push_exp(32'h4);
    push_exp(32'h100);
    sb_en = 1'b1;
    for (int i = 0; i < 40 && acc_q.size() < 3; i++) begin
      @(negedge clk);
      #3;
    end
    check("wait_req8", {32'd0, acc_at(2)}, 64'h8);
    @(negedge clk);
    branch_valid  = 1'b1;
    branch        = 2'b01;
    branch_target = 32'h100;
    @(negedge clk);
    branch_valid = 1'b0;
    #3;
    check("kill_flush", {63'd0, flush}, 64'd1);
    @(negedge clk);
    #3;
    check("kill_flush_pulse", {63'd0, flush}, 64'd0);
    drain("kill_drain");
    check("kill_new_req", {32'd0, acc_at(3)}, 64'h100);

    // Redirect in the same cycle as the response: dropped, no KILL.
    do_reset(1, 1'b1, 1'b1);
    push_exp(32'h200);
    sb_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      #1;
      found = imem_rsp_valid;
    end
    check("rsp_seen", {63'd0, found}, 64'd1);
    branch_valid = 1'b1;
    branch       = 2'b10;
    alu_out      = 32'h200;
    @(negedge clk);
    branch_valid = 1'b0;
    #3;
    check("drop_req_now", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, 32'h200});
    check("drop_flush", {63'd0, flush}, 64'd1);
    check("drop_if_valid", {63'd0, if_valid}, 64'd0);
    drain("drop_drain");

    // Redirect while a request is held by ready low: old request completes, then KILL.
    do_reset(1, 1'b0, 1'b1);
    push_exp(32'h40);
    sb_en = 1'b1;
    @(negedge clk);
    #3;
    check("hold_req", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, 32'h0});
    @(negedge clk);
    branch_valid  = 1'b1;
    branch        = 2'b01;
    branch_target = 32'h40;
    #3;
    check("hold_during_redirect", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, 32'h0});
    @(negedge clk);
    branch_valid = 1'b0;
    #3;
    check("hold_flush", {63'd0, flush}, 64'd1);
    check("hold_after_redirect", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, 32'h0});
    @(negedge clk);
    mem_ready = 1'b1;
    drain("hold_drain");
    check("hold_req0", {32'd0, acc_at(0)}, 64'h0);
    check("hold_req1", {32'd0, acc_at(1)}, 64'h40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
